// File: rtl/fpu_resp_fanout.sv
// Shared-FPU response return path: routes each result to the requesting core's
// small FIFO by the low ID bits; only a full target FIFO backpressures the FPU.
module fpu_resp_fanout #(
    parameter int unsigned NB_CORES   = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FLAG_WIDTH = 5,
    parameter int unsigned ID_WIDTH   = 9,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  data_r_valid_i,
    output logic                                  data_r_ready_o,
    input  logic [DATA_WIDTH-1:0]                 data_r_rdata_i,
    input  logic [FLAG_WIDTH-1:0]                 data_r_flag_i,
    input  logic [ID_WIDTH-1:0]                   data_r_ID_i,
    output logic [NB_CORES-1:0]                   data_r_valid_o,
    input  logic [NB_CORES-1:0]                   data_r_ready_i,
    output logic [NB_CORES-1:0][DATA_WIDTH-1:0]   data_r_rdata_o,
    output logic [NB_CORES-1:0][FLAG_WIDTH-1:0]   data_r_flag_o,
    output logic                                  id_err_o
);

    localparam int unsigned DEST_W = $clog2(NB_CORES);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_data [NB_CORES][FIFO_DEPTH];
    logic [FLAG_WIDTH-1:0] r_flag [NB_CORES][FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr [NB_CORES];
    logic [PTR_W-1:0]      r_rptr [NB_CORES];
    logic [CNT_W-1:0]      r_cnt  [NB_CORES];
    logic                  r_id_err;

    logic [DEST_W-1:0]     w_dest;
    logic                  w_in_range;
    logic [NB_CORES-1:0]   w_full;
    logic [NB_CORES-1:0]   w_push;
    logic [NB_CORES-1:0]   w_pop;

    assign w_dest     = data_r_ID_i[DEST_W-1:0];
    assign w_in_range = (data_r_ID_i < ID_WIDTH'(NB_CORES));

    // Ready looks only at registered counts, so a same-cycle pop never frees a slot.
    always_comb begin
        w_full = '0;
        w_push = '0;
        w_pop  = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            w_full[c] = (r_cnt[c] == CNT_W'(FIFO_DEPTH));
            w_pop[c]  = (r_cnt[c] != '0) && data_r_ready_i[c];
        end
        data_r_ready_o = w_in_range ? ~w_full[w_dest] : 1'b1;
        for (int c = 0; c < NB_CORES; c++) begin
            w_push[c] = data_r_valid_i && w_in_range && !w_full[c] &&
                        (w_dest == DEST_W'(c));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_err <= 1'b0;
            for (int c = 0; c < NB_CORES; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_cnt[c]  <= '0;
                for (int e = 0; e < FIFO_DEPTH; e++) begin
                    r_data[c][e] <= '0;
                    r_flag[c][e] <= '0;
                end
            end
        end else begin
            r_id_err <= data_r_valid_i && !w_in_range;
            for (int c = 0; c < NB_CORES; c++) begin
                if (w_push[c]) begin
                    r_data[c][r_wptr[c]] <= data_r_rdata_i;
                    r_flag[c][r_wptr[c]] <= data_r_flag_i;
                    r_wptr[c]            <= r_wptr[c] + PTR_W'(1);
                end
                if (w_pop[c]) begin
                    r_rptr[c] <= r_rptr[c] + PTR_W'(1);
                end
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                    2'b01:   r_cnt[c] <= r_cnt[c] - CNT_W'(1);
                    default: r_cnt[c] <= r_cnt[c];
                endcase
            end
        end
    end

    // Head of each FIFO drives the core interface directly.
    always_comb begin
        data_r_valid_o = '0;
        data_r_rdata_o = '0;
        data_r_flag_o  = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            data_r_valid_o[c] = (r_cnt[c] != '0);
            data_r_rdata_o[c] = r_data[c][r_rptr[c]];
            data_r_flag_o[c]  = r_flag[c][r_rptr[c]];
        end
    end

    assign id_err_o = r_id_err;

endmodule

// File: tb/tb_fpu_resp_fanout.sv
// Directed bench for fpu_resp_fanout with 8 cores, 2-entry FIFOs.
module tb_fpu_resp_fanout;

    localparam int unsigned NB_CORES   = 8;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned FLAG_WIDTH = 5;
    localparam int unsigned ID_WIDTH   = 9;
    localparam int unsigned FIFO_DEPTH = 2;

    logic                                clk = 1'b0;
    logic                                rst_n;
    logic                                data_r_valid_i;
    logic                                data_r_ready_o;
    logic [DATA_WIDTH-1:0]               data_r_rdata_i;
    logic [FLAG_WIDTH-1:0]               data_r_flag_i;
    logic [ID_WIDTH-1:0]                 data_r_ID_i;
    logic [NB_CORES-1:0]                 data_r_valid_o;
    logic [NB_CORES-1:0]                 data_r_ready_i;
    logic [NB_CORES-1:0][DATA_WIDTH-1:0] data_r_rdata_o;
    logic [NB_CORES-1:0][FLAG_WIDTH-1:0] data_r_flag_o;
    logic                                id_err_o;

    int n_tot = 0;
    int n_bad = 0;

    fpu_resp_fanout #(
        .NB_CORES  (NB_CORES),
        .DATA_WIDTH(DATA_WIDTH),
        .FLAG_WIDTH(FLAG_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_r_valid_i(data_r_valid_i),
        .data_r_ready_o(data_r_ready_o),
        .data_r_rdata_i(data_r_rdata_i),
        .data_r_flag_i (data_r_flag_i),
        .data_r_ID_i   (data_r_ID_i),
        .data_r_valid_o(data_r_valid_o),
        .data_r_ready_i(data_r_ready_i),
        .data_r_rdata_o(data_r_rdata_o),
        .data_r_flag_o (data_r_flag_o),
        .id_err_o      (id_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ID_WIDTH-1:0] id,
                         input logic [DATA_WIDTH-1:0] d, input logic [FLAG_WIDTH-1:0] f);
        data_r_valid_i = v;
        data_r_ID_i    = id;
        data_r_rdata_i = d;
        data_r_flag_i  = f;
    endtask

    logic [DATA_WIDTH-1:0] exp_q[$];
    int sent;
    int rcvd;
    int cyc;

    initial begin
        rst_n          = 1'b0;
        data_r_ready_i = '1;
        drive(1'b0, '0, '0, '0);
        #12;
        chk("rst_valid_o", 64'(data_r_valid_o), 64'h0);
        chk("rst_id_err", 64'(id_err_o), 64'h0);
        chk("rst_rdata3", 64'(data_r_rdata_o[3]), 64'h0);
        chk("rst_ready_o", 64'(data_r_ready_o), 64'h1);
        rst_n = 1'b1;
        tick();

        // single response to core 3
        drive(1'b1, 9'd3, 32'hDEADBEEF, 5'h01);
        #1;
        chk("s1_ready", 64'(data_r_ready_o), 64'h1);
        tick();
        drive(1'b0, '0, '0, '0);
        chk("s1_valid_o", 64'(data_r_valid_o), 64'h08);
        chk("s1_rdata3", 64'(data_r_rdata_o[3]), 64'hDEADBEEF);
        chk("s1_flag3", 64'(data_r_flag_o[3]), 64'h01);
        tick();
        chk("s1_popped", 64'(data_r_valid_o), 64'h0);

        // core 2 stalled: fill, backpressure, other core unaffected
        data_r_ready_i = 8'hFB;
        drive(1'b1, 9'd2, 32'hA1, 5'h02);
        #1;
        chk("s2_rdy_a1", 64'(data_r_ready_o), 64'h1);
        tick();
        drive(1'b1, 9'd2, 32'hA2, 5'h03);
        #1;
        chk("s2_rdy_a2", 64'(data_r_ready_o), 64'h1);
        tick();
        drive(1'b1, 9'd2, 32'hA3, 5'h04);
        #1;
        chk("s2_rdy_a3_full", 64'(data_r_ready_o), 64'h0);
        chk("s2_head_a1", 64'(data_r_rdata_o[2]), 64'hA1);
        tick();
        drive(1'b1, 9'd5, 32'h55, 5'h05);
        #1;
        chk("s3_rdy_id5", 64'(data_r_ready_o), 64'h1);
        tick();
        drive(1'b0, '0, '0, '0);
        chk("s3_valid_o", 64'(data_r_valid_o), 64'h24);
        chk("s3_rdata5", 64'(data_r_rdata_o[5]), 64'h55);
        chk("s3_head2_stable", 64'(data_r_rdata_o[2]), 64'hA1);
        tick();
        chk("s3_core5_popped", 64'(data_r_valid_o), 64'h04);
        drive(1'b1, 9'd2, 32'hA3, 5'h04);
        data_r_ready_i = '1;
        #1;
        chk("s2_no_bypass", 64'(data_r_ready_o), 64'h0);
        tick();
        chk("s2_head_a2", 64'(data_r_rdata_o[2]), 64'hA2);
        chk("s2_rdy_after_pop", 64'(data_r_ready_o), 64'h1);
        tick();
        drive(1'b0, '0, '0, '0);
        #1;
        chk("s2_head_a3", 64'(data_r_rdata_o[2]), 64'hA3);
        chk("s2_flag_a3", 64'(data_r_flag_o[2]), 64'h04);
        chk("s2_valid_a3", 64'(data_r_valid_o), 64'h04);
        tick();
        chk("s2_drained", 64'(data_r_valid_o), 64'h0);

        // out-of-range ID is accepted, dropped, and flagged for one cycle
        drive(1'b1, 9'h1FF, 32'hBAD, 5'h1F);
        #1;
        chk("s4_ready", 64'(data_r_ready_o), 64'h1);
        tick();
        drive(1'b0, '0, '0, '0);
        chk("s4_id_err", 64'(id_err_o), 64'h1);
        chk("s4_no_valid", 64'(data_r_valid_o), 64'h0);
        tick();
        chk("s4_id_err_clr", 64'(id_err_o), 64'h0);
        chk("s4_no_valid2", 64'(data_r_valid_o), 64'h0);

        // 16-entry stream to core 1 with toggling ready
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 16 && cyc < 200) begin
            data_r_ready_i[1] = (cyc % 2 == 0);
            if (sent < 16) drive(1'b1, 9'd1, 32'h100 + 32'(sent), 5'(sent));
            else           drive(1'b0, '0, '0, '0);
            #1;
            if (data_r_valid_o[1] && data_r_ready_i[1]) begin
                if (exp_q.size() == 0) begin
                    chk("s5_unexpected", 64'(data_r_rdata_o[1]), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("s5_order", 64'(data_r_rdata_o[1]), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                rcvd++;
            end
            if (data_r_valid_i && data_r_ready_o) begin
                exp_q.push_back(data_r_rdata_i);
                sent++;
            end
            tick();
            cyc++;
        end
        drive(1'b0, '0, '0, '0);
        data_r_ready_i = '1;
        chk("s5_sent", 64'(sent), 64'd16);
        chk("s5_rcvd", 64'(rcvd), 64'd16);
        chk("s5_empty", 64'(data_r_valid_o), 64'h0);

        // fill cores 0 and 4, then reset mid-transfer
        data_r_ready_i = '0;
        drive(1'b1, 9'd0, 32'hC0, 5'h01); tick();
        drive(1'b1, 9'd0, 32'hC1, 5'h01); tick();
        drive(1'b1, 9'd4, 32'hC4, 5'h02); tick();
        drive(1'b1, 9'd4, 32'hC5, 5'h02); tick();
        drive(1'b1, 9'd0, 32'hC2, 5'h01);
        #1;
        chk("s6_filled", 64'(data_r_valid_o), 64'h11);
        chk("s6_full0", 64'(data_r_ready_o), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("s6_async_clr", 64'(data_r_valid_o), 64'h0);
        chk("s6_rdata0_clr", 64'(data_r_rdata_o[0]), 64'h0);
        chk("s6_rdata4_clr", 64'(data_r_rdata_o[4]), 64'h0);
        drive(1'b0, '0, '0, '0);
        #1;
        rst_n = 1'b1;
        data_r_ready_i = '1;
        tick();
        chk("s6_no_stale", 64'(data_r_valid_o), 64'h0);
        tick();
        chk("s6_no_stale2", 64'(data_r_valid_o), 64'h0);
        chk("s6_id_err", 64'(id_err_o), 64'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
